// File: rtl/misc_v_pkg.sv
// Shared decode definitions for the immediate generator: format codes, opcode patterns, field positions.
// Latency: none (package only).
// Backpressure: not applicable.
package misc_v_pkg;

    // Format codes as they appear on out_type.
    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_M = 3'd2,
        FMT_Y = 3'd3,
        FMT_J = 3'd4
    } fmt_e;

    // Opcode occupies the top three bits of the instruction word.
    localparam int OPC_W = 3;

    // Raw immediate field positions (lsb, width) per format.
    localparam int R_LSB  = 0;
    localparam int R_W    = 4;
    localparam int I_LSB  = 2;
    localparam int I_W    = 4;
    localparam int M_LSB  = 0;
    localparam int M_W    = 7;
    localparam int YJ_LSB = 0;
    localparam int YJ_W   = 13;

    // Opcode -> format: 000 R, 001 I, 01x M, 10x Y, 11x J.
    function automatic fmt_e decode_fmt(input logic [OPC_W-1:0] opc);
        fmt_e f;
        casez (opc)
            3'b000:  f = FMT_R;
            3'b001:  f = FMT_I;
            3'b01?:  f = FMT_M;
            3'b10?:  f = FMT_Y;
            default: f = FMT_J;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/imm_extract.sv
// Decodes the format of one instruction and produces its sign-extended (Y/J: scaled) immediate.
// Latency: purely combinational.
// Backpressure: none; ports: instr in, imm/fmt out.
module imm_extract
    import misc_v_pkg::*;
#(
    parameter int IW       = 16,
    parameter int XLEN     = 16,
    parameter int SHIFT_YJ = 0
) (
    input  logic [IW-1:0]   instr,
    output logic [XLEN-1:0] imm,
    output fmt_e            fmt
);

    always_comb begin
        fmt = decode_fmt(instr[IW-1 -: OPC_W]);
        imm = '0;
        case (fmt)
            FMT_R: imm = {{(XLEN-R_W){instr[R_LSB+R_W-1]}}, instr[R_LSB +: R_W]};
            FMT_I: imm = {{(XLEN-I_W){instr[I_LSB+I_W-1]}}, instr[I_LSB +: I_W]};
            FMT_M: imm = {{(XLEN-M_W){instr[M_LSB+M_W-1]}}, instr[M_LSB +: M_W]};
            // Scaling happens after extension so the sign is carried into the upper bits;
            // bits shifted past XLEN are simply dropped.
            FMT_Y, FMT_J:
                imm = {{(XLEN-YJ_W){instr[YJ_LSB+YJ_W-1]}}, instr[YJ_LSB +: YJ_W]} << SHIFT_YJ;
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Two-stage immediate generator: S1 holds the raw instruction, S2 the decoded immediate and format.
// Latency: 2 cycles from acceptance to out_valid; 1 instruction/cycle with out_ready high.
// Backpressure: valid/ready; in_ready = S1 empty or S1 advancing, gated off by flush and reset.
// Ports: clk, rst_n (async active-low), in_valid/in_ready/in_instr, flush,
//        out_valid/out_ready/out_imm/out_type.
module imm_gen_pipe
    import misc_v_pkg::*;
#(
    parameter int IW       = 16,
    parameter int XLEN     = 16,
    parameter int SHIFT_YJ = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [IW-1:0]   in_instr,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_type
);

    logic            s1_vld_q, s1_vld_d;
    logic [IW-1:0]   s1_instr_q, s1_instr_d;
    logic            s2_vld_q, s2_vld_d;
    logic [XLEN-1:0] s2_imm_q, s2_imm_d;
    logic [2:0]      s2_type_q, s2_type_d;

    logic            s2_adv;
    logic            s1_adv;
    logic            in_fire;
    logic [XLEN-1:0] ext_imm;
    fmt_e            ext_fmt;

    imm_extract #(
        .IW       (IW),
        .XLEN     (XLEN),
        .SHIFT_YJ (SHIFT_YJ)
    ) u_imm_extract (
        .instr (s1_instr_q),
        .imm   (ext_imm),
        .fmt   (ext_fmt)
    );

    always_comb begin
        // A stage can take new data when it is empty or its content leaves this cycle.
        s2_adv   = !s2_vld_q || out_ready;
        s1_adv   = !s1_vld_q || s2_adv;
        // rst_n gates in_ready so nothing is advertised while reset is held.
        in_ready = rst_n && !flush && s1_adv;
        in_fire  = in_valid && in_ready;

        s1_vld_d   = s1_vld_q;
        s1_instr_d = s1_instr_q;
        s2_vld_d   = s2_vld_q;
        s2_imm_d   = s2_imm_q;
        s2_type_d  = s2_type_q;

        if (s1_adv) begin
            s1_vld_d = in_fire;
        end
        if (in_fire) begin
            s1_instr_d = in_instr;
        end

        if (s2_adv) begin
            s2_vld_d = s1_vld_q;
            if (s1_vld_q) begin
                s2_imm_d  = ext_imm;
                s2_type_d = ext_fmt;
            end
        end

        // Flush wins over everything; a simultaneous output handshake has already completed.
        if (flush) begin
            s1_vld_d = 1'b0;
            s2_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q   <= 1'b0;
            s1_instr_q <= '0;
            s2_vld_q   <= 1'b0;
            s2_imm_q   <= '0;
            s2_type_q  <= '0;
        end else begin
            s1_vld_q   <= s1_vld_d;
            s1_instr_q <= s1_instr_d;
            s2_vld_q   <= s2_vld_d;
            s2_imm_q   <= s2_imm_d;
            s2_type_q  <= s2_type_d;
        end
    end

    assign out_valid = s2_vld_q;
    assign out_imm   = s2_imm_q;
    assign out_type  = s2_type_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: default and XLEN=32/SHIFT_YJ=1 instances.
// Latency: inputs driven 1ns after posedge, outputs sampled on negedge.
// Backpressure: exercised through out_ready stalls, flush and mid-stream reset.
module tb_imm_gen_pipe;

    logic        clk;
    logic        rst_n;

    logic        in_valid, in_ready, flush, out_valid, out_ready;
    logic [15:0] in_instr, out_imm;
    logic [2:0]  out_type;

    logic        w_in_valid, w_in_ready, w_flush, w_out_valid, w_out_ready;
    logic [15:0] w_in_instr;
    logic [31:0] w_out_imm;
    logic [2:0]  w_out_type;

    int n_tests = 0;
    int n_fail  = 0;

    imm_gen_pipe u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_imm   (out_imm),
        .out_type  (out_type)
    );

    imm_gen_pipe #(.IW(16), .XLEN(32), .SHIFT_YJ(1)) u_dut_w (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (w_in_valid),
        .in_ready  (w_in_ready),
        .in_instr  (w_in_instr),
        .flush     (w_flush),
        .out_valid (w_out_valid),
        .out_ready (w_out_ready),
        .out_imm   (w_out_imm),
        .out_type  (w_out_type)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Hand-computed vectors.
    logic [15:0] v_in [6]  = '{16'h0001, 16'h0008, 16'h2020, 16'h4040, 16'h9000, 16'hF000};
    logic [15:0] v_imm[6]  = '{16'h0001, 16'hFFF8, 16'hFFF8, 16'hFFC0, 16'hF000, 16'hF000};
    logic [2:0]  v_typ[6]  = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
    logic [15:0] w_in [3]  = '{16'hD000, 16'hA001, 16'h6040};
    logic [31:0] w_imm[3]  = '{32'hFFFFE000, 32'h00000002, 32'hFFFFFFC0};
    logic [2:0]  w_typ[3]  = '{3'd4, 3'd3, 3'd2};
    logic [15:0] bp_in[4]  = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};

    initial begin
        int k;
        int n;

        rst_n = 1'b1;
        in_valid = 1'b0; in_instr = '0; flush = 1'b0; out_ready = 1'b1;
        w_in_valid = 1'b0; w_in_instr = '0; w_flush = 1'b0; w_out_ready = 1'b1;

        // Reset state, checked before any clock edge.
        #1 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_imm", {16'd0, out_imm}, 32'd0);
        chk("rst_out_type", {29'd0, out_type}, 32'd0);
        chk("rst_w_out_imm", w_out_imm, 32'd0);
        @(posedge clk);
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("post_rst_w_in_ready", {31'd0, w_in_ready}, 32'd1);
        next_cycle();

        // Back-to-back, default parameters.
        for (int j = 0; j < 8; j++) begin
            in_valid = (j < 6);
            in_instr = (j < 6) ? v_in[j] : 16'h0;
            @(negedge clk);
            chk($sformatf("b2b_in_ready_%0d", j), {31'd0, in_ready}, 32'd1);
            if (j >= 2) begin
                chk($sformatf("b2b_valid_%0d", j), {31'd0, out_valid}, 32'd1);
                chk($sformatf("b2b_imm_%0d", j), {16'd0, out_imm}, {16'd0, v_imm[j-2]});
                chk($sformatf("b2b_type_%0d", j), {29'd0, out_type}, {29'd0, v_typ[j-2]});
            end else begin
                chk($sformatf("b2b_empty_%0d", j), {31'd0, out_valid}, 32'd0);
            end
            next_cycle();
        end
        in_valid = 1'b0;

        // Back-to-back, XLEN=32 SHIFT_YJ=1.
        for (int j = 0; j < 5; j++) begin
            w_in_valid = (j < 3);
            w_in_instr = (j < 3) ? w_in[j] : 16'h0;
            @(negedge clk);
            if (j >= 2) begin
                chk($sformatf("w_valid_%0d", j), {31'd0, w_out_valid}, 32'd1);
                chk($sformatf("w_imm_%0d", j), w_out_imm, w_imm[j-2]);
                chk($sformatf("w_type_%0d", j), {29'd0, w_out_type}, {29'd0, w_typ[j-2]});
            end else begin
                chk($sformatf("w_empty_%0d", j), {31'd0, w_out_valid}, 32'd0);
            end
            next_cycle();
        end
        w_in_valid = 1'b0;
        next_cycle();

        // Backpressure: out_ready low for 5 cycles while streaming 4 instructions.
        k = 0;
        n = 0;
        for (int it = 0; it < 20 && n < 4; it++) begin
            out_ready = (it >= 5);
            if (k < 4) begin
                in_valid = 1'b1;
                in_instr = bp_in[k];
            end else begin
                in_valid = 1'b0;
                in_instr = 16'h0;
            end
            @(negedge clk);
            if (it == 2) begin
                chk("bp_accepts_before_stall", k, 32'd2);
                chk("bp_in_ready_full", {31'd0, in_ready}, 32'd0);
            end
            if (out_valid) begin
                // While stalled this also checks the output holds the same entry.
                chk($sformatf("bp_imm_%0d", it), {16'd0, out_imm}, n + 1);
                chk($sformatf("bp_type_%0d", it), {29'd0, out_type}, 32'd0);
                if (out_ready) n++;
            end
            if (in_valid && in_ready) k++;
            next_cycle();
        end
        chk("bp_accepted", k, 32'd4);
        chk("bp_emitted", n, 32'd4);
        in_valid = 1'b0;
        out_ready = 1'b1;
        next_cycle();

        // Flush with two entries in flight.
        in_valid = 1'b1; in_instr = 16'h0005;
        next_cycle();
        in_instr = 16'h0006;
        next_cycle();
        flush = 1'b1; in_instr = 16'h0007;
        @(negedge clk);
        chk("fl_in_ready", {31'd0, in_ready}, 32'd0);
        chk("fl_out_valid_before", {31'd0, out_valid}, 32'd1);
        chk("fl_out_imm_before", {16'd0, out_imm}, 32'h5);
        next_cycle();
        flush = 1'b0; in_instr = 16'h0003;
        @(negedge clk);
        chk("fl_out_valid_after", {31'd0, out_valid}, 32'd0);
        chk("fl_in_ready_after", {31'd0, in_ready}, 32'd1);
        next_cycle();
        in_valid = 1'b0;
        @(negedge clk);
        chk("fl_lat_1", {31'd0, out_valid}, 32'd0);
        next_cycle();
        @(negedge clk);
        chk("fl_lat_2_valid", {31'd0, out_valid}, 32'd1);
        chk("fl_lat_2_imm", {16'd0, out_imm}, 32'h3);
        next_cycle();
        @(negedge clk);
        chk("fl_no_dup", {31'd0, out_valid}, 32'd0);
        next_cycle();

        // Asynchronous reset mid-stream.
        in_valid = 1'b1; in_instr = 16'h0008;
        next_cycle();
        in_instr = 16'h2020;
        next_cycle();
        in_valid = 1'b0;
        @(negedge clk);
        chk("ar_pre_valid", {31'd0, out_valid}, 32'd1);
        chk("ar_pre_imm", {16'd0, out_imm}, 32'hFFF8);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_out_valid", {31'd0, out_valid}, 32'd0);
        chk("ar_out_imm", {16'd0, out_imm}, 32'd0);
        chk("ar_out_type", {29'd0, out_type}, 32'd0);
        chk("ar_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        chk("ar_rel_in_ready", {31'd0, in_ready}, 32'd1);
        chk("ar_rel_valid", {31'd0, out_valid}, 32'd0);
        next_cycle();
        @(negedge clk);
        chk("ar_no_stale", {31'd0, out_valid}, 32'd0);
        next_cycle();
        in_valid = 1'b1; in_instr = 16'h4040;
        next_cycle();
        in_valid = 1'b0;
        next_cycle();
        @(negedge clk);
        chk("ar_new_valid", {31'd0, out_valid}, 32'd1);
        chk("ar_new_imm", {16'd0, out_imm}, 32'hFFC0);
        chk("ar_new_type", {29'd0, out_type}, 32'd2);
        next_cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 Parameter IW, default 16: instruction width; opcode field is instr[IW-1:IW-3].
REQ-002 Parameter XLEN, default 16: immediate output width; legal values are >= 16.
REQ-003 Parameter SHIFT_YJ, default 0: left shift applied to Y/J immediates; legal values are 0..2.
REQ-004 Port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-005 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 Port in_valid, input, 1: the instruction on in_instr is valid.
REQ-007 Port in_ready, output, 1: the block accepts in_instr this cycle.
REQ-008 Port in_instr, input, IW: the instruction word.
REQ-009 Port flush, input, 1: synchronously discard all in-flight entries.
REQ-010 Port out_valid, output, 1: out_imm and out_type are valid.
REQ-011 Port out_ready, input, 1: downstream accepts the output this cycle.
REQ-012 Port out_imm, output, XLEN: the sign-extended (and scaled) immediate.
REQ-013 Port out_type, output, 3: format code R=0, I=1, M=2, Y=3, J=4.

Function
REQ-014 The format SHALL be decoded from instr[15:13]: 000 R; 001 I; 01x M; 10x Y; 11x J.
REQ-015 The raw field SHALL be: R = instr[3:0]; I = instr[5:2]; M = instr[6:0]; Y = instr[12:0]; J = instr[12:0].
REQ-016 out_imm SHALL be the raw field sign-extended from its MSB to XLEN bits.
REQ-017 For Y and J only, the result SHALL be shifted left by SHIFT_YJ, zero-filled and truncated to XLEN.
REQ-018 The pipeline SHALL have two register stages: S1 captures the raw instruction; S2 holds the decoded immediate and type.
REQ-019 Latency SHALL be exactly 2 cycles from the accepting edge to out_valid when out_ready is held high.
REQ-020 Throughput SHALL be 1 instruction per cycle while out_ready=1.
REQ-021 A transfer SHALL occur on an edge where valid and ready are both high.
REQ-022 Each stage SHALL advance when it is empty or when its successor advances; in_ready SHALL be high when S1 is empty or S1 advances.
REQ-023 in_ready SHALL depend on out_ready combinationally; no combinational path is permitted from in_valid to out_valid.
REQ-024 While out_valid=1 and out_ready=0, out_imm and out_type SHALL hold stable, and no entry is lost or duplicated.
REQ-025 When both stages are full and out_ready=0, in_ready SHALL be 0.
REQ-026 flush=1 SHALL clear both valid bits at the next edge and force in_ready=0 in that cycle; an input presented during flush is not accepted.
REQ-027 flush takes priority over a simultaneous output handshake; the output transfer in that cycle still counts as completed.
REQ-028 Order SHALL be preserved: outputs appear in acceptance order.

Reset
REQ-029 rst_n=0 SHALL asynchronously clear the S1/S2 valid bits, out_imm=0 and out_type=0; out_valid=0 and in_ready=0 while reset is asserted.
REQ-030 Reset asserted mid-operation SHALL discard all in-flight entries.
REQ-031 After deassertion, in_ready SHALL be 1 in the first cycle.

Structure
REQ-032 Format codes, opcode patterns and field positions SHALL live in shared package misc_v_pkg.
REQ-033 Field extraction, sign extension and shift SHALL be one combinational sub-module, imm_extract, instantiated between S1 and S2.

Verification
REQ-034 Defaults, back-to-back with out_ready=1: 0x0001 -> 0x0001 R; 0x0008 -> 0xFFF8 R; 0x2020 -> 0xFFF8 I; 0x4040 -> 0xFFC0 M; 0x9000 -> 0xF000 Y; 0xF000 -> 0xF000 J. One result per cycle, 2-cycle latency.
REQ-035 XLEN=32, SHIFT_YJ=1: 0xD000 -> 0xFFFFE000 J; 0xA001 -> 0x00000002 Y; 0x6040 -> 0xFFFFFFC0 M, unshifted.
REQ-036 Backpressure: hold out_ready=0 for 5 cycles while streaming 4 instructions. in_ready drops after 2 accepts; output holds stable; all 4 emerge in order once out_ready=1.
REQ-037 Flush with 2 entries in flight: out_valid=0 the next cycle; in_ready=0 during the flush cycle; the next accepted instruction emerges 2 cycles later.
REQ-038 Assert rst_n low asynchronously mid-stream: outputs clear immediately without a clock edge; in_ready=1 in the first cycle after release; no stale output appears.
